// File: rtl/wb_mailbox_slave.sv
// Wishbone B4 pipelined slave: byte-writable test register, push-only mailbox FIFO,
// status/clear register and read-only ID, all answered with a one-cycle registered response.
module wb_mailbox_slave #(
    parameter int          DEPTH = 8,
    parameter logic [31:0] ID    = 32'h5742_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic [31:0] o_test_reg,
    output logic [31:0] o_mbox_data,
    output logic        o_mbox_valid,
    input  logic        i_mbox_pop
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [31:0]   test_q, test_d, rdata_q, rdata_d;
    logic          ack_q, ack_d, err_q, err_d;
    logic          full, empty, accept, wr, push, pop;
    logic [31:0]   rd_mux;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign o_wb_stall = i_wb_we & (i_wb_addr == 2'd1) & full;
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign wr         = accept & i_wb_we;
    assign push       = wr & (i_wb_addr == 2'd1);
    // A pop is only honoured against the registered count, so a same-cycle push into an empty FIFO is never popped.
    assign pop        = i_mbox_pop & ~empty;

    always_comb begin
        rd_mux = ID;
        case (i_wb_addr)
            2'd0:    rd_mux = test_q;
            2'd1:    rd_mux = empty ? 32'd0 : mem_q[rptr_q];
            2'd2:    rd_mux = {err_cnt_q, 6'b0, empty, full, 16'(count_q)};
            default: rd_mux = ID;
        endcase
    end

    always_comb begin
        test_d    = test_q;
        err_cnt_d = err_cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        rdata_d   = (accept & ~i_wb_we) ? rd_mux : rdata_q;
        err_d     = wr & (i_wb_addr == 2'd3);
        ack_d     = accept & ~err_d;

        for (int i = 0; i < 4; i++) begin
            if (wr && (i_wb_addr == 2'd0) && i_wb_sel[i]) begin
                test_d[8*i +: 8] = i_wb_data[8*i +: 8];
            end
        end

        if (wr && (i_wb_addr == 2'd2) && i_wb_sel[0] && i_wb_data[0]) begin
            err_cnt_d = 8'd0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            test_q    <= 32'd0;
            err_cnt_q <= 8'd0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rdata_q   <= 32'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            test_q    <= test_d;
            err_cnt_q <= err_cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Storage needs no reset: the pointers and count define which words are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= i_wb_data;
    end

    // Dropping cyc abandons the cycle, so the registered response is masked while cyc is low.
    assign o_wb_ack     = ack_q & i_wb_cyc;
    assign o_wb_err     = err_q & i_wb_cyc;
    assign o_wb_data    = rdata_q;
    assign o_test_reg   = test_q;
    assign o_mbox_valid = ~empty;
    assign o_mbox_data  = empty ? 32'd0 : mem_q[rptr_q];
endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Self-checking bench for wb_mailbox_slave: expected bus responses are queued at issue time
// and popped when the response cycle arrives; a small FIFO/err_cnt model supplies status values.
module tb_wb_mailbox_slave;
  localparam logic [31:0] ID_C = 32'h5742_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [1:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic [3:0]  i_wb_sel;
  logic        o_wb_ack, o_wb_err, o_wb_stall;
  logic [31:0] o_wb_data, o_test_reg, o_mbox_data;
  logic        o_mbox_valid, i_mbox_pop;

  int vectors = 0;
  int miscompares = 0;
  logic [33:0] exp_q[$];
  logic [31:0] mb_q[$];
  logic [7:0]  err_m;
  logic [31:0] last_rdata;

  wb_mailbox_slave #(.DEPTH(8), .ID(ID_C)) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_stall(o_wb_stall),
    .o_wb_data(o_wb_data), .o_test_reg(o_test_reg),
    .o_mbox_data(o_mbox_data), .o_mbox_valid(o_mbox_valid), .i_mbox_pop(i_mbox_pop)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, exp finished");
    $fatal(1);
  end

  function automatic logic [31:0] status_m();
    int n;
    n = mb_q.size();
    return {err_m, 6'b0, (n == 0), (n == 8), 16'(n)};
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0; i_wb_sel = 0;
    i_mbox_pop = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); mb_q.delete(); err_m = 0; last_rdata = 0;
  endtask

  // driver tasks
  task automatic idle();
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [1:0] addr, input logic [31:0] data,
                       input logic [3:0] sel, input logic is_err, input logic [31:0] rd);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_addr = addr; i_wb_data = data; i_wb_sel = sel;
    if (we) exp_q.push_back({~is_err, is_err, last_rdata});
    else begin
      last_rdata = rd;
      exp_q.push_back({2'b10, rd});
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic drain(input string name);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    while (mb_q.size() > 0) begin
      vectors++;
      if (o_mbox_data !== mb_q[0] || o_mbox_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL %s head: got %h/%b exp %h/1", name, o_mbox_data, o_mbox_valid, mb_q[0]);
      end
      i_mbox_pop = 1;
      @(posedge clk);
      void'(mb_q.pop_front());
      @(negedge clk);
      i_mbox_pop = 0;
    end
    vectors++;
    if (o_mbox_valid !== 1'b0 || o_mbox_data !== 32'd0) begin
      miscompares++;
      $display("FAIL %s empty: got %h/%b exp 0/0", name, o_mbox_data, o_mbox_valid);
    end
  endtask

  task automatic test_reset();
    logic [99:0] got;
    apply_reset();
    got = {o_wb_ack, o_wb_err, o_mbox_valid, o_wb_stall, o_wb_data, o_test_reg, o_mbox_data};
    vectors++;
    if (got !== '0) begin miscompares++; $display("FAIL reset outputs: got %h exp 0", got); end
    i_wb_we = 1; i_wb_addr = 2'd1; #1;
    vectors++;
    if (o_wb_stall !== 1'b0) begin miscompares++; $display("FAIL reset stall: got %b exp 0", o_wb_stall); end
    i_wb_we = 0; i_wb_addr = 0;
  endtask

  task automatic test_byte_lanes();
    logic [33:0] got, e;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: issue(1, 2'd0, 32'h1122_3344, 4'b1111, 0, 0);
        1: issue(1, 2'd0, 32'hAABB_CCDD, 4'b0101, 0, 0);
        default: issue(0, 2'd0, 0, 4'b1111, 0, 32'h11BB_33DD);
      endcase
      got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL bytelane resp %0d: got %h exp %h", k, got, e); end
    end
    vectors++;
    if (o_test_reg !== 32'h11BB_33DD) begin
      miscompares++; $display("FAIL bytelane test_reg: got %h exp 11bb33dd", o_test_reg);
    end
    idle();
  endtask

  task automatic test_fill_stall();
    logic [33:0] got, e;
    for (int i = 1; i <= 8; i++) begin
      issue(1, 2'd1, 32'(i), 4'b0000, 0, 0);
      mb_q.push_back(32'(i));
      got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL fill push %0d: got %h exp %h", i, got, e); end
    end
    issue(0, 2'd2, 0, 4'b1111, 0, status_m());
    got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
    if (got !== e || e[31:0] !== 32'h0001_0008) begin
      miscompares++; $display("FAIL fill status: got %h exp %h", got, e);
    end
    vectors++;
    if (o_mbox_data !== 32'd1) begin miscompares++; $display("FAIL fill head: got %h exp 1", o_mbox_data); end
    i_wb_we = 1; i_wb_addr = 2'd1; i_wb_data = 32'd9; i_wb_sel = 4'hF; #1;
    vectors++;
    if (o_wb_stall !== 1'b1) begin miscompares++; $display("FAIL stall full: got %b exp 1", o_wb_stall); end
    @(posedge clk); @(negedge clk);
    vectors++;
    if (o_wb_ack !== 1'b0 || o_wb_stall !== 1'b1) begin
      miscompares++; $display("FAIL stall hold: got ack %b stall %b exp 0 1", o_wb_ack, o_wb_stall);
    end
    i_mbox_pop = 1;
    @(posedge clk);
    void'(mb_q.pop_front());
    @(negedge clk);
    i_mbox_pop = 0;
    vectors++;
    if (o_wb_stall !== 1'b0 || o_mbox_data !== 32'd2) begin
      miscompares++; $display("FAIL stall release: got stall %b head %h exp 0 2", o_wb_stall, o_mbox_data);
    end
    exp_q.push_back({2'b10, last_rdata});
    mb_q.push_back(32'd9);
    @(posedge clk); @(negedge clk);
    got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL fill push 9: got %h exp %h", got, e); end
    drain("fill");
  endtask

  task automatic test_push_pop();
    logic [33:0] got, e;
    for (int i = 0; i < 3; i++) begin
      issue(1, 2'd1, 32'hA0 + 32'(i), 4'hF, 0, 0);
      mb_q.push_back(32'hA0 + 32'(i));
      got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL pushpop pre %0d: got %h exp %h", i, got, e); end
    end
    i_mbox_pop = 1;
    issue(1, 2'd1, 32'hA3, 4'hF, 0, 0);
    i_mbox_pop = 0;
    void'(mb_q.pop_front());
    mb_q.push_back(32'hA3);
    got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL pushpop same: got %h exp %h", got, e); end
    issue(0, 2'd2, 0, 4'hF, 0, status_m());
    got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
    if (got !== e || e[15:0] !== 16'd3) begin miscompares++; $display("FAIL pushpop count: got %h exp %h", got, e); end
    issue(0, 2'd1, 0, 4'hF, 0, 32'hA1);
    got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL pushpop peek: got %h exp %h", got, e); end
    drain("pushpop");
    i_mbox_pop = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (o_mbox_valid !== 1'b0 || o_mbox_data !== 32'd0) begin
        miscompares++; $display("FAIL empty pop %0d: got %h/%b exp 0/0", i, o_mbox_data, o_mbox_valid);
      end
    end
    i_mbox_pop = 0;
    issue(0, 2'd2, 0, 4'hF, 0, status_m());
    got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL empty status: got %h exp %h", got, e); end
    idle();
  endtask

  task automatic test_errors();
    logic [33:0] got, e;
    for (int i = 0; i < 3 + 1 + 1 + 260 + 1 + 1 + 1 + 1 + 1; i++) begin
      if (i < 3 || (i >= 5 && i < 265)) begin
        issue(1, 2'd3, $urandom, 4'(($urandom_range(0, 15))), 1, 0);
        if (err_m != 8'hFF) err_m++;
      end else if (i == 3 || i == 265 || i == 268) begin
        issue(0, 2'd2, 0, 4'hF, 0, status_m());
      end else if (i == 266) begin
        issue(1, 2'd2, 32'd1, 4'b1110, 0, 0);
      end else if (i == 267) begin
        issue(1, 2'd2, 32'hFFFF_FFFE, 4'b1111, 0, 0);
      end else begin
        issue(1, 2'd2, 32'd1, 4'b0001, 0, 0);
        err_m = 0;
      end
      got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL errpath step %0d: got %h exp %h", i, got, e); end
    end
    issue(0, 2'd2, 0, 4'hF, 0, status_m());
    got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
    if (got !== e || e[31:24] !== 8'd0) begin miscompares++; $display("FAIL errpath clear: got %h exp %h", got, e); end
    idle();
  endtask

  task automatic test_abort();
    logic [33:0] got, e;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 2'd3; i_wb_sel = 4'hF;
    last_rdata = ID_C;
    @(posedge clk); #1;
    i_wb_cyc = 0; i_wb_stb = 0;
    #1;
    vectors++;
    if (o_wb_ack !== 1'b0 || o_wb_err !== 1'b0) begin
      miscompares++; $display("FAIL abort read: got ack %b err %b exp 0 0", o_wb_ack, o_wb_err);
    end
    @(negedge clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = 2'd1; i_wb_data = 32'hCAFE_0001;
    @(posedge clk); #1;
    i_wb_cyc = 0; i_wb_stb = 0;
    mb_q.push_back(32'hCAFE_0001);
    #1;
    vectors++;
    if (o_wb_ack !== 1'b0 || o_wb_err !== 1'b0) begin
      miscompares++; $display("FAIL abort push: got ack %b err %b exp 0 0", o_wb_ack, o_wb_err);
    end
    @(negedge clk);
    issue(0, 2'd2, 0, 4'hF, 0, status_m());
    got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
    if (got !== e || e[15:0] !== 16'd1) begin miscompares++; $display("FAIL abort count: got %h exp %h", got, e); end
    drain("abort");
  endtask

  task automatic test_reset_mid();
    logic [33:0] got, e;
    logic [99:0] outs;
    for (int i = 0; i < 5; i++) begin
      issue(1, 2'd1, $urandom, 4'hF, 0, 0);
      mb_q.push_back(i_wb_data);
      got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL rstmid push %0d: got %h exp %h", i, got, e); end
    end
    i_wb_we = 0; i_wb_addr = 2'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    outs = {o_wb_ack, o_wb_err, o_mbox_valid, o_wb_stall, o_wb_data, o_test_reg, o_mbox_data};
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL rstmid outputs: got %h exp 0", outs); end
    i_wb_cyc = 0; i_wb_stb = 0;
    exp_q.delete(); mb_q.delete(); err_m = 0; last_rdata = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) issue(0, 2'd2, 0, 4'hF, 0, 32'h0002_0000);
      else        issue(0, 2'd3, 0, 4'hF, 0, ID_C);
      got = {o_wb_ack, o_wb_err, o_wb_data}; e = exp_q.pop_front(); vectors++;
      if (got !== e) begin miscompares++; $display("FAIL rstmid read %0d: got %h exp %h", k, got, e); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_fill_stall();
    test_push_pop();
    test_errors();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
